// File: rtl/alu_decode_stage.sv
// MIPS decode stage: turns a 32-bit instruction into ALU function code and
// writeback controls, behind a two-entry skid buffer with valid/ready on both sides.
module alu_decode_stage #(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr_in,
    input  logic        Valid_in,
    output logic        Ready_out,
    input  logic        Flush_in,
    output logic        Valid_out,
    input  logic        Ready_in,
    output logic [5:0]  Func_out,
    output logic        UseImm_out,
    output logic [31:0] Imm_out,
    output logic        RegWrite_out,
    output logic [4:0]  DestReg_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Illegal_out
);

    typedef struct packed {
        logic [5:0]  func;
        logic        use_imm;
        logic [31:0] imm;
        logic        reg_write;
        logic [4:0]  dest;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] sext;
        logic [31:0] zext;
        op   = ins[31:26];
        fn   = ins[5:0];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sext = {{16{ins[15]}}, ins[15:0]};
        zext = {16'h0, ins[15:0]};
        d    = '0;
        if (ins != 32'h0) begin
            unique case (op)
                6'h00: begin
                    d.reg_write = 1'b1;
                    d.dest      = rd;
                    unique case (fn)
                        6'h20, 6'h21: d.func = 6'b100000;
                        6'h22, 6'h23: d.func = 6'b100010;
                        6'h24, 6'h25, 6'h26, 6'h27: d.func = {4'b1001, fn[1:0]};
                        6'h2A, 6'h2B: d.func = fn;
                        6'h09:        d.func = 6'b111011;
                        6'h08: begin
                            d.func      = 6'b111011;
                            d.reg_write = 1'b0;
                            d.dest      = 5'd0;
                        end
                        default: begin
                            d.reg_write = 1'b0;
                            d.dest      = 5'd0;
                            d.illegal   = 1'b1;
                        end
                    endcase
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
                    d.use_imm   = 1'b1;
                    d.reg_write = 1'b1;
                    d.dest      = rt;
                    d.imm       = sext;
                    unique case (op)
                        6'h0A:   d.func = 6'b101010;
                        6'h0B:   d.func = 6'b101011;
                        6'h0C:   begin d.func = 6'b100100; d.imm = zext; end
                        6'h0D:   begin d.func = 6'b100101; d.imm = zext; end
                        6'h0E:   begin d.func = 6'b100110; d.imm = zext; end
                        6'h0F:   begin d.func = 6'b000000; d.imm = {ins[15:0], 16'h0}; end
                        6'h23:   begin d.func = 6'b100000; d.mem_read = 1'b1; end
                        default: d.func = 6'b100000;
                    endcase
                end
                6'h2B: begin
                    d.func      = 6'b100000;
                    d.use_imm   = 1'b1;
                    d.imm       = sext;
                    d.mem_write = 1'b1;
                end
                6'h01: begin
                    if (rt[4:1] == 4'd0) begin
                        d.func = {5'b11100, rt[0]};
                        d.imm  = sext;
                    end else begin
                        d.illegal = 1'b1;
                    end
                end
                6'h04, 6'h05, 6'h06, 6'h07: begin
                    d.func = {4'b1111, op[1:0]};
                    d.imm  = sext;
                end
                6'h02: d.func = 6'b111010;
                6'h03: begin
                    d.func      = 6'b111010;
                    d.reg_write = 1'b1;
                    d.dest      = LINK_REG;
                end
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    state_t state_q, state_d;
    dec_t   out_q, skid_q, in_dec;
    logic   accept, drain;
    logic   load_out, load_skid, move_skid;

    assign in_dec    = decode(Instr_in);
    assign Ready_out = (state_q != FULL);
    assign Valid_out = (state_q != EMPTY);
    assign accept    = Valid_in && Ready_out && !Flush_in;
    assign drain     = Valid_out && Ready_in;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (Flush_in) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Data registers are not cleared by flush; Valid_out alone hides stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out)  out_q  <= in_dec;
            if (move_skid) out_q  <= skid_q;
            if (load_skid) skid_q <= in_dec;
        end
    end

    assign Func_out     = out_q.func;
    assign UseImm_out   = out_q.use_imm;
    assign Imm_out      = out_q.imm;
    assign RegWrite_out = out_q.reg_write;
    assign DestReg_out  = out_q.dest;
    assign MemRead_out  = out_q.mem_read;
    assign MemWrite_out = out_q.mem_write;
    assign Illegal_out  = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed decode vectors, backpressure,
// flush, asynchronous reset and a randomized stream against a table-driven model.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [5:0]  func;
        logic        use_imm;
        logic [31:0] imm;
        logic        reg_write;
        logic [4:0]  dest;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instr_in = '0;
    logic        Valid_in = 1'b0;
    logic        Ready_out;
    logic        Flush_in = 1'b0;
    logic        Valid_out;
    logic        Ready_in = 1'b0;
    logic [5:0]  Func_out;
    logic        UseImm_out;
    logic [31:0] Imm_out;
    logic        RegWrite_out;
    logic [4:0]  DestReg_out;
    logic        MemRead_out;
    logic        MemWrite_out;
    logic        Illegal_out;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    bit   stop_rdy = 0;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .Instr_in(Instr_in), .Valid_in(Valid_in),
        .Ready_out(Ready_out), .Flush_in(Flush_in), .Valid_out(Valid_out),
        .Ready_in(Ready_in), .Func_out(Func_out), .UseImm_out(UseImm_out),
        .Imm_out(Imm_out), .RegWrite_out(RegWrite_out), .DestReg_out(DestReg_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Illegal_out(Illegal_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t cur_out();
        return '{Func_out, UseImm_out, Imm_out, RegWrite_out, DestReg_out,
                 MemRead_out, MemWrite_out, Illegal_out};
    endfunction

    function automatic exp_t mk(input logic [5:0] f, input logic ui, input logic [31:0] imm,
                                input logic rw, input logic [4:0] d, input logic mr,
                                input logic mw, input logic il);
        return '{f, ui, imm, rw, d, mr, mw, il};
    endfunction

    // Reference decode straight from the opcode/funct tables.
    function automatic exp_t model(input logic [31:0] ins);
        int          op, fn, rt, rd;
        logic [31:0] se, ze;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        if (ins == 32'h0) return '0;
        if (op == 0) begin
            if (fn == 'h20 || fn == 'h21) return mk(6'h20, 0, 0, 1, 5'(rd), 0, 0, 0);
            if (fn == 'h22 || fn == 'h23) return mk(6'h22, 0, 0, 1, 5'(rd), 0, 0, 0);
            if (fn >= 'h24 && fn <= 'h27) return mk(6'(fn), 0, 0, 1, 5'(rd), 0, 0, 0);
            if (fn == 'h2A) return mk(6'h2A, 0, 0, 1, 5'(rd), 0, 0, 0);
            if (fn == 'h2B) return mk(6'h2B, 0, 0, 1, 5'(rd), 0, 0, 0);
            if (fn == 'h08) return mk(6'h3B, 0, 0, 0, 0, 0, 0, 0);
            if (fn == 'h09) return mk(6'h3B, 0, 0, 1, 5'(rd), 0, 0, 0);
            return mk(0, 0, 0, 0, 0, 0, 0, 1);
        end
        case (op)
            'h08, 'h09: return mk(6'h20, 1, se, 1, 5'(rt), 0, 0, 0);
            'h0A: return mk(6'h2A, 1, se, 1, 5'(rt), 0, 0, 0);
            'h0B: return mk(6'h2B, 1, se, 1, 5'(rt), 0, 0, 0);
            'h0C: return mk(6'h24, 1, ze, 1, 5'(rt), 0, 0, 0);
            'h0D: return mk(6'h25, 1, ze, 1, 5'(rt), 0, 0, 0);
            'h0E: return mk(6'h26, 1, ze, 1, 5'(rt), 0, 0, 0);
            'h0F: return mk(6'h00, 1, ze << 16, 1, 5'(rt), 0, 0, 0);
            'h23: return mk(6'h20, 1, se, 1, 5'(rt), 1, 0, 0);
            'h2B: return mk(6'h20, 1, se, 0, 0, 0, 1, 0);
            'h01: if (rt == 0) return mk(6'h38, 0, se, 0, 0, 0, 0, 0);
                  else if (rt == 1) return mk(6'h39, 0, se, 0, 0, 0, 0, 0);
            'h04: return mk(6'h3C, 0, se, 0, 0, 0, 0, 0);
            'h05: return mk(6'h3D, 0, se, 0, 0, 0, 0, 0);
            'h06: return mk(6'h3E, 0, se, 0, 0, 0, 0, 0);
            'h07: return mk(6'h3F, 0, se, 0, 0, 0, 0, 0);
            'h02: return mk(6'h3A, 0, 0, 0, 0, 0, 0, 0);
            'h03: return mk(6'h3A, 0, 0, 1, 5'd31, 0, 0, 0);
            default: ;
        endcase
        return mk(0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        int          fl[10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
        int          ol[17] = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B,
                                'h04, 'h05, 'h06, 'h07, 'h02, 'h03, 'h01};
        int          k;
        r = $urandom;
        k = $urandom_range(0, 19);
        if (k < 10)       r = {6'h00, r[25:6], 6'(fl[k])};
        else if (k == 10) r = {6'h00, r[25:6], 6'h08};
        else if (k == 11) r = {6'h00, r[25:6], 6'h09};
        else begin
            k = $urandom_range(0, 16);
            r[31:26] = 6'(ol[k]);
            if (ol[k] == 'h01) r[20:16] = {4'd0, r[0]};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present one instruction and push its expectation when the transfer is certain.
    task automatic send(input logic [31:0] ins, input exp_t e);
        int n = 0;
        Valid_in = 1'b1;
        Instr_in = ins;
        @(negedge clk);
        while (!Ready_out && n < 200) begin @(negedge clk); n++; end
        if (!Ready_out) begin
            check("send_timeout", 0, 1);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        Valid_in = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int n = 0;
        Ready_in = 1'b1;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check(name, 64'(sb.size()), 0);
    endtask

    // Monitor: compares each output transfer, checks stability while stalled.
    exp_t prev_out;
    bit   prev_stall = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall <= 0;
        end else begin
            if (prev_stall) check("hold_stable", 64'(cur_out()), 64'(prev_out));
            if (Valid_out && Ready_in) begin
                if (sb.size() == 0) check("unexpected_output", 64'(cur_out()), 0);
                else check("decode", 64'(cur_out()), 64'(sb.pop_front()));
            end
            if (Flush_in) sb.delete();
            prev_stall <= Valid_out && !Ready_in && !Flush_in;
            prev_out   <= cur_out();
        end
    end

    initial begin
        #2;
        check("rst_valid", 64'(Valid_out), 0);
        check("rst_ready", 64'(Ready_out), 1);
        check("rst_outs",  64'(cur_out()), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        Ready_in = 1'b1;

        send(32'h012A4020, mk(6'h20, 0, 0, 1, 8, 0, 0, 0));
        send(32'h2128FFFF, mk(6'h20, 1, 32'hFFFFFFFF, 1, 8, 0, 0, 0));
        send(32'h3128FFFF, mk(6'h24, 1, 32'h0000FFFF, 1, 8, 0, 0, 0));
        send(32'h3C081234, mk(6'h00, 1, 32'h12340000, 1, 8, 0, 0, 0));
        send(32'h04210003, mk(6'h39, 0, 32'h3, 0, 0, 0, 0, 0));
        send(32'h0C000010, mk(6'h3A, 0, 0, 1, 31, 0, 0, 0));
        send(32'h01200008, mk(6'h3B, 0, 0, 0, 0, 0, 0, 0));
        send(32'hFC000000, mk(6'h00, 0, 0, 0, 0, 0, 0, 1));
        send(32'h00000000, mk(6'h00, 0, 0, 0, 0, 0, 0, 0));
        send(32'h8D0A0004, mk(6'h20, 1, 32'h4, 1, 10, 1, 0, 0));
        send(32'hAD0AFFF0, mk(6'h20, 1, 32'hFFFFFFF0, 0, 0, 0, 1, 0));
        send(32'h04450000, mk(6'h00, 0, 0, 0, 0, 0, 0, 1));
        drain_all("drain_directed");

        // Backpressure: two accepts fill the buffer.
        Ready_in = 1'b0;
        send(32'h012A4020, model(32'h012A4020));
        check("bp_ready_one", 64'(Ready_out), 1);
        send(32'h3128FFFF, model(32'h3128FFFF));
        check("bp_ready_full", 64'(Ready_out), 0);
        fork
            begin
                send(32'h3C081234, model(32'h3C081234));
                send(32'h0C000010, model(32'h0C000010));
            end
            begin repeat (3) @(posedge clk); #1; Ready_in = 1'b1; end
        join
        drain_all("drain_bp");

        // Flush while FULL with a simultaneous valid input.
        Ready_in = 1'b0;
        send(32'h2128FFFF, model(32'h2128FFFF));
        send(32'h3128FFFF, model(32'h3128FFFF));
        Valid_in = 1'b1; Instr_in = 32'h012A4020; Flush_in = 1'b1;
        @(posedge clk); #1;
        Valid_in = 1'b0; Flush_in = 1'b0;
        check("flush_valid", 64'(Valid_out), 0);
        check("flush_ready", 64'(Ready_out), 1);
        Ready_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset from FULL.
        Ready_in = 1'b0;
        send(32'h2128FFFF, model(32'h2128FFFF));
        send(32'h0C000010, model(32'h0C000010));
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(Valid_out), 0);
        check("arst_ready", 64'(Ready_out), 1);
        check("arst_outs",  64'(cur_out()), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_empty", 64'(Valid_out), 0);

        // Random stream with random downstream stalls.
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [31:0] ins;
                    ins = rand_legal();
                    send(ins, model(ins));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                stop_rdy = 1;
            end
            begin
                while (!stop_rdy) begin @(posedge clk); #1; Ready_in = 1'($urandom); end
            end
        join
        drain_all("drain_random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
